// File: rtl/bp_me_cmd_requester_pkg.sv
// Shared BedRock memory-interface types for the command requester:
// header layout, message enums, FSM states and the size-to-beats helper.
package bp_me_cmd_requester_pkg;

  localparam int paddr_width_p  = 40;
  localparam int did_width_p    = 4;
  localparam int dword_width_gp = 64;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd  = 4'b0000,
    e_bedrock_mem_wr  = 4'b0001,
    e_bedrock_mem_amo = 4'b0010
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [did_width_p-1:0] did;
  } bp_bedrock_mem_payload_s;

  typedef struct packed {
    bp_bedrock_mem_payload_s payload;
    bp_bedrock_msg_size_e    size;
    logic [paddr_width_p-1:0] addr;
    bp_bedrock_mem_type_e    msg_type;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_send  = 2'd1,
    e_wait  = 2'd2,
    e_done  = 2'd3
  } requester_state_e;

  // Number of dword beats a message of this size occupies (at least one).
  function automatic logic [3:0] size_to_beats(input logic [2:0] size);
    logic [6:0] bytes;
    bytes = 7'd1 << size;
    if (bytes < 7'd8) begin
      return 4'd1;
    end
    return 4'(bytes >> 3);
  endfunction

endpackage

// File: rtl/bp_me_cmd_requester_sipo.sv
// Response beat assembler: packs incoming dword beats into a block in
// arrival order, ignores beats once the block is full, and zeroes bits
// beyond the message size for sub-dword responses.
module bp_me_cmd_requester_sipo
  import bp_me_cmd_requester_pkg::*;
  #(parameter int block_width_p = 512)
  (input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      clear_i,
   input  logic                      v_i,
   input  logic [dword_width_gp-1:0] data_i,
   input  logic [2:0]                size_i,
   output logic [block_width_p-1:0]  data_o
  );

  localparam int beats_lp     = block_width_p / dword_width_gp;
  localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  logic [cnt_width_lp-1:0]  cnt_reg;
  logic                     full_reg;
  logic                     store;
  logic [block_width_p-1:0] raw_data;
  logic [block_width_p-1:0] size_mask;

  assign store = v_i & ~full_reg;

  // Write pointer: advances per stored beat, sticks once the last slot is used
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else if (clear_i) begin
      cnt_reg  <= '0;
      full_reg <= 1'b0;
    end else if (store) begin
      if (cnt_reg == cnt_width_lp'(beats_lp - 1)) begin
        full_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < beats_lp; gi++) begin : g_beat
    logic [dword_width_gp-1:0] beat_reg;

    // Capture the beat addressed by the write pointer
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        beat_reg <= '0;
      end else if (clear_i) begin
        beat_reg <= '0;
      end else if (store && (cnt_reg == cnt_width_lp'(gi))) begin
        beat_reg <= data_i;
      end
    end

    assign raw_data[gi*dword_width_gp +: dword_width_gp] = beat_reg;
  end

  // Sub-dword messages keep only their low 8<<size bits
  always_comb begin
    size_mask = '1;
    if (size_i < 3'd3) begin
      size_mask = ~({block_width_p{1'b1}} << (8 << size_i));
    end
  end

  assign data_o = raw_data & size_mask;

endmodule

// File: rtl/bp_me_cmd_requester.sv
// Single-outstanding BedRock memory-command initiator: issues one command
// (header plus write beats), gathers the response, hands it back whole.
module bp_me_cmd_requester
  import bp_me_cmd_requester_pkg::*;
  #(parameter int block_width_p = 512)
  (input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           req_v_i,
   output logic                           req_ready_and_o,
   input  logic                           req_write_i,
   input  logic [paddr_width_p-1:0]       req_addr_i,
   input  logic [2:0]                     req_size_i,
   input  logic [did_width_p-1:0]         req_did_i,
   input  logic [block_width_p-1:0]       req_data_i,
   output logic                           resp_v_o,
   input  logic                           resp_yumi_i,
   output logic [block_width_p-1:0]       resp_data_o,
   output logic                           resp_err_o,
   output logic [mem_header_width_lp-1:0] mem_cmd_header_o,
   output logic                           mem_cmd_header_v_o,
   input  logic                           mem_cmd_header_ready_and_i,
   output logic                           mem_cmd_has_data_o,
   output logic [dword_width_gp-1:0]      mem_cmd_data_o,
   output logic                           mem_cmd_data_v_o,
   input  logic                           mem_cmd_data_ready_and_i,
   output logic                           mem_cmd_last_o,
   input  logic [mem_header_width_lp-1:0] mem_resp_header_i,
   input  logic                           mem_resp_header_v_i,
   output logic                           mem_resp_header_ready_and_o,
   input  logic                           mem_resp_has_data_i,
   input  logic [dword_width_gp-1:0]      mem_resp_data_i,
   input  logic                           mem_resp_data_v_i,
   output logic                           mem_resp_data_ready_and_o,
   input  logic                           mem_resp_last_i
  );

  localparam int beats_lp     = block_width_p / dword_width_gp;
  localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  requester_state_e state_reg, state_next;

  logic                       init_done_reg;
  logic                       req_write_reg;
  logic [paddr_width_p-1:0]   req_addr_reg;
  logic [2:0]                 req_size_reg;
  logic [did_width_p-1:0]     req_did_reg;
  logic [block_width_p-1:0]   req_data_reg;
  logic                       hdr_sent_reg;
  logic                       last_sent_reg;
  logic [cnt_width_lp-1:0]    cmd_cnt_reg;
  logic                       resp_hdr_seen_reg;
  logic                       resp_last_seen_reg;
  logic                       resp_has_data_reg;
  logic                       resp_err_reg;

  logic req_fire, cmd_hdr_fire, cmd_data_fire, resp_hdr_fire, resp_data_fire;
  logic cmd_hdr_done, cmd_data_done;
  logic resp_hdr_done, resp_has_data, resp_last_done, resp_done, resp_mismatch;
  logic [cnt_width_lp-1:0]    cmd_last_idx;
  logic [beats_lp-1:0][dword_width_gp-1:0] req_beats;
  logic [block_width_p-1:0]   sipo_data;
  logic                       sipo_clear, sipo_v;
  bp_bedrock_mem_type_e       cmd_msg_type;
  bp_bedrock_mem_header_s     cmd_hdr, resp_hdr;
  logic                       unused_resp_fields;

  assign req_fire       = req_v_i & req_ready_and_o;
  assign cmd_hdr_fire   = mem_cmd_header_v_o & mem_cmd_header_ready_and_i;
  assign cmd_data_fire  = mem_cmd_data_v_o & mem_cmd_data_ready_and_i;
  assign resp_hdr_fire  = mem_resp_header_v_i & mem_resp_header_ready_and_o;
  assign resp_data_fire = mem_resp_data_v_i & mem_resp_data_ready_and_o;

  assign cmd_msg_type = req_write_reg ? e_bedrock_mem_wr : e_bedrock_mem_rd;
  assign cmd_last_idx = cnt_width_lp'(size_to_beats(req_size_reg) - 4'd1);
  assign req_beats    = req_data_reg;

  // Command side completes once the header and (for writes) the last beat are taken
  assign cmd_hdr_done  = hdr_sent_reg | cmd_hdr_fire;
  assign cmd_data_done = ~req_write_reg | last_sent_reg | (cmd_data_fire & mem_cmd_last_o);

  // Response side: header and last beat may arrive in either order or together
  assign resp_hdr       = mem_resp_header_i;
  assign resp_hdr_done  = resp_hdr_seen_reg | resp_hdr_fire;
  assign resp_has_data  = resp_hdr_fire ? mem_resp_has_data_i : resp_has_data_reg;
  assign resp_last_done = resp_last_seen_reg | (resp_data_fire & mem_resp_last_i);
  assign resp_done      = resp_hdr_done & (~resp_has_data | resp_last_done);
  assign resp_mismatch  = (resp_hdr.msg_type != cmd_msg_type) | (resp_hdr.addr != req_addr_reg);
  assign unused_resp_fields = ^{resp_hdr.size, resp_hdr.payload};

  always_comb begin
    cmd_hdr             = '0;
    cmd_hdr.msg_type    = cmd_msg_type;
    cmd_hdr.addr        = req_addr_reg;
    cmd_hdr.size        = bp_bedrock_msg_size_e'(req_size_reg);
    cmd_hdr.payload.did = req_did_reg;
  end

  assign mem_cmd_header_o   = cmd_hdr;
  assign mem_cmd_has_data_o = req_write_reg;
  assign mem_cmd_data_o     = req_beats[cmd_cnt_reg];
  assign mem_cmd_last_o     = mem_cmd_data_v_o & (cmd_cnt_reg == cmd_last_idx);

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg <= e_ready;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      e_ready: if (req_fire) state_next = e_send;
      e_send:  if (cmd_hdr_done && cmd_data_done) state_next = e_wait;
      e_wait:  if (resp_done) state_next = e_done;
      e_done:  if (resp_yumi_i) state_next = e_ready;
      default: state_next = e_ready;
    endcase
  end

  // Handshake outputs per state; idle state sinks stray responses
  always_comb begin
    req_ready_and_o             = 1'b0;
    mem_cmd_header_v_o          = 1'b0;
    mem_cmd_data_v_o            = 1'b0;
    mem_resp_header_ready_and_o = 1'b0;
    mem_resp_data_ready_and_o   = 1'b0;
    resp_v_o                    = 1'b0;
    unique case (state_reg)
      e_ready: begin
        req_ready_and_o             = init_done_reg;
        mem_resp_header_ready_and_o = 1'b1;
        mem_resp_data_ready_and_o   = 1'b1;
      end
      e_send: begin
        mem_cmd_header_v_o = ~hdr_sent_reg;
        mem_cmd_data_v_o   = req_write_reg & ~last_sent_reg;
      end
      e_wait: begin
        mem_resp_header_ready_and_o = 1'b1;
        mem_resp_data_ready_and_o   = 1'b1;
      end
      e_done: resp_v_o = 1'b1;
      default: ;
    endcase
  end

  // Request capture, command progress and response bookkeeping
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      init_done_reg      <= 1'b0;
      req_write_reg      <= 1'b0;
      req_addr_reg       <= '0;
      req_size_reg       <= '0;
      req_did_reg        <= '0;
      req_data_reg       <= '0;
      hdr_sent_reg       <= 1'b0;
      last_sent_reg      <= 1'b0;
      cmd_cnt_reg        <= '0;
      resp_hdr_seen_reg  <= 1'b0;
      resp_last_seen_reg <= 1'b0;
      resp_has_data_reg  <= 1'b0;
      resp_err_reg       <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      unique case (state_reg)
        e_ready: begin
          if (req_fire) begin
            req_write_reg      <= req_write_i;
            req_addr_reg       <= req_addr_i;
            req_size_reg       <= req_size_i;
            req_did_reg        <= req_did_i;
            req_data_reg       <= req_data_i;
            hdr_sent_reg       <= 1'b0;
            last_sent_reg      <= 1'b0;
            cmd_cnt_reg        <= '0;
            resp_hdr_seen_reg  <= 1'b0;
            resp_last_seen_reg <= 1'b0;
            resp_has_data_reg  <= 1'b0;
            resp_err_reg       <= 1'b0;
          end
        end
        e_send: begin
          if (cmd_hdr_fire) hdr_sent_reg <= 1'b1;
          if (cmd_data_fire) begin
            if (mem_cmd_last_o) last_sent_reg <= 1'b1;
            else                cmd_cnt_reg   <= cmd_cnt_reg + 1'b1;
          end
        end
        e_wait: begin
          if (resp_hdr_fire) begin
            resp_hdr_seen_reg <= 1'b1;
            resp_has_data_reg <= mem_resp_has_data_i;
            resp_err_reg      <= resp_mismatch;
          end
          if (resp_data_fire && mem_resp_last_i) resp_last_seen_reg <= 1'b1;
        end
        e_done: begin
          if (resp_yumi_i) resp_err_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sipo_clear = (state_reg == e_done) & resp_yumi_i;
  assign sipo_v     = (state_reg == e_wait) & resp_data_fire;

  bp_me_cmd_requester_sipo #(.block_width_p(block_width_p)) u_sipo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (sipo_clear),
    .v_i     (sipo_v),
    .data_i  (mem_resp_data_i),
    .size_i  (req_size_reg),
    .data_o  (sipo_data)
  );

  assign resp_data_o = req_write_reg ? '0 : sipo_data;
  assign resp_err_o  = resp_err_reg;

endmodule
